// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO transmit stage and its paired deserializer.
package piso_serializer_pkg;
   localparam int DEF_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;
endpackage

// File: rtl/piso_serializer_if.sv
// Producer-side handshake plus serial output bundle of the PISO transmit stage.
import piso_serializer_pkg::*;

interface piso_serializer_if #(parameter int WIDTH = DEF_WIDTH);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             frame_last;
   logic             busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, ser_out, ser_valid, frame_last, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, ser_out, ser_valid, frame_last, busy
   );
endinterface

// File: rtl/piso_serializer_word_hold_buf.sv
// One-word holding buffer; in_ready is purely the inverse of the full flag.
import piso_serializer_pkg::*;

module piso_serializer_word_hold_buf #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full,
   output logic             in_ready
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (load) begin
         hold      <= load_data;
         hold_full <= 1'b1;
      end else if (drain) begin
         hold_full <= 1'b0;
      end
   end

   assign in_ready = !hold_full;
endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with a one-word holding buffer
// so consecutive frames stream without idle cycles.
import piso_serializer_pkg::*;

module piso_serializer #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   piso_serializer_if.slave      bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   state_e           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             in_ready;
   logic             accept;
   logic             load;
   logic             drain;

   assign accept = bus.in_valid && in_ready;

   piso_serializer_word_hold_buf #(.WIDTH(WIDTH)) word_hold_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .drain     (drain),
      .load_data (bus.in_data),
      .hold      (hold),
      .hold_full (hold_full),
      .in_ready  (in_ready)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // At the last-bit cycle the held word wins over a new one; in_ready is
   // already low then, so the two can never collide.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      load      = 1'b0;
      drain     = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
               shreg_nxt = bus.in_data;
               cnt_nxt   = CNT_TOP;
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
               cnt_nxt   = cnt - CW'(1);
               load      = accept;
            end else if (hold_full) begin
               shreg_nxt = hold;
               cnt_nxt   = CNT_TOP;
               drain     = 1'b1;
            end else if (accept) begin
               shreg_nxt = bus.in_data;
               cnt_nxt   = CNT_TOP;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ser_out    = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
   assign bus.ser_valid  = (state == SHIFT);
   assign bus.frame_last = (state == SHIFT) && (cnt == '0);
   assign bus.in_ready   = in_ready;
   assign bus.busy       = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// Randomised and directed checks of piso_serializer against a bit-queue model
// plus a behavioural downstream deserializer.
module tb_piso_serializer;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(W)) bus ();

   piso_serializer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: queue of pending {bit, is_last} pairs; front is the bit on the wire.
   logic [1:0]   bitq[$];
   logic [W-1:0] wordq[$];
   logic [W-1:0] sipo;
   bit           last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic ev;
      ev = (bitq.size() != 0);
      chk("ser_valid",  32'(bus.ser_valid),  32'(ev));
      chk("ser_out",    32'(bus.ser_out),    ev ? 32'(bitq[0][1]) : 32'd0);
      chk("frame_last", 32'(bus.frame_last), ev ? 32'(bitq[0][0]) : 32'd0);
      chk("in_ready",   32'(bus.in_ready),   32'(bitq.size() <= W));
      chk("busy",       32'(bus.busy),       32'(ev));
   endtask

   task automatic model_reset();
      bitq.delete();
      wordq.delete();
      sipo = '0;
   endtask

   // One clock: drive inputs, advance the model across the edge, check #1 after.
   task automatic cycle(input logic v, input logic [W-1:0] d);
      logic pre_valid, pre_out, pre_last;
      logic [W-1:0] exp_word;
      pre_valid = bus.ser_valid;
      pre_out   = bus.ser_out;
      pre_last  = bus.frame_last;
      bus.in_valid = v;
      bus.in_data  = d;
      last_acc = v && (bitq.size() <= W);
      @(posedge clk);
      if (bitq.size() != 0) void'(bitq.pop_front());
      if (last_acc) begin
         for (int i = W - 1; i >= 0; i--) bitq.push_back({d[i], (i == 0)});
         wordq.push_back(d);
      end
      if (pre_valid) sipo = {sipo[W-2:0], pre_out};
      if (pre_last) begin
         exp_word = (wordq.size() != 0) ? wordq.pop_front() : ~sipo;
         chk("sipo_word", 32'(sipo), 32'(exp_word));
      end
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [W-1:0] d);
      int guard;
      guard = 0;
      do begin
         cycle(1'b1, d);
         guard++;
      end while (!last_acc && guard < 20);
      if (!last_acc) chk("send_timeout", 32'(guard), 32'd0);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0);
   endtask

   initial begin
      bit           pend;
      logic [W-1:0] pw;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      model_reset();
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_outputs();

      // Single word 1011
      send(4'b1011);
      idle(6);

      // Streaming A,5,F with valid held high
      bus.in_valid = 1'b1;
      send(4'hA);
      send(4'h5);
      send(4'hF);
      idle(10);

      // Bypass: second word offered only in the last-bit cycle
      send(4'h9);
      idle(3);
      chk("bypass_last_cycle", 32'(bus.frame_last), 32'd1);
      send(4'h6);
      idle(6);

      // Reset mid-frame: C shifting, 3 held
      send(4'hC);
      send(4'h3);
      idle(1);
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1 rst = 1'b0;
      check_outputs();
      send(4'h6);
      idle(6);

      // Randomised producer that holds its word until accepted
      pend = 1'b0;
      pw   = '0;
      for (int c = 0; c < 400; c++) begin
         if (!pend && $urandom_range(0, 9) < 6) begin
            pend = 1'b1;
            pw   = W'($urandom);
         end
         cycle(pend, pw);
         if (last_acc) pend = 1'b0;
      end
      idle(12);
      chk("drained", 32'(wordq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmit stage that feeds the 4-bit serial-in/parallel-out shift register. It accepts words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock. The first bit transmitted therefore lands in the deserializer's highest output bit after WIDTH clocks. A one-word holding buffer lets consecutive words stream with no idle cycle between frames.

## Interface
- WIDTH, default 4: word width and frame length in bits. Legal range is WIDTH ≥ 2. Must equal the downstream deserializer depth.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high. Clears all state immediately.
- in_data  input  WIDTH  parallel word to transmit. Sampled only on an accepted handshake.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word. High exactly when the holding buffer is empty.
- ser_out  output  1  serial data, registered. Drives the deserializer's serial input.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_last  output  1  ser_out carries bit 0, the final bit of the current word.
- busy  output  1  shifter holds a frame in progress, or the holding buffer is full.

## Operation
- **Handshake:** a word is accepted on any rising edge where in_valid && in_ready. in_data is not required to stay stable after acceptance.
- **Storage:** a WIDTH-bit shift register (shreg), a down-counter cnt of width $clog2(WIDTH), a WIDTH-bit holding register (hold) and a hold_full flag.
- **State machine (2 states, IDLE and SHIFT):**
  - IDLE → SHIFT on an accepted word: shreg ← in_data, cnt ← WIDTH-1.
  - SHIFT, with cnt ≠ 0: shreg shifts left by one, cnt decrements.
  - SHIFT, with cnt = 0 (last-bit cycle): the next source is chosen in this priority order:
    - hold_full set: shreg ← hold, hold_full clears, cnt ← WIDTH-1, stay in SHIFT.
    - otherwise an accepted word: shreg ← in_data directly (bypass), stay in SHIFT.
    - otherwise: go to IDLE.
  - SHIFT, not the last-bit cycle, with an accepted word: hold ← in_data, hold_full sets.
- **Outputs:**
  - ser_out = shreg[WIDTH-1] while in SHIFT; 0 in IDLE.
  - ser_valid = (state == SHIFT).
  - frame_last = (state == SHIFT && cnt == 0).
  - in_ready = !hold_full, derived from registers only with no combinational path from in_valid.
  - busy = (state == SHIFT) || hold_full.
- **Ordering:** words are transmitted in acceptance order. None is dropped or duplicated.

## Timing
- **Reset values:** ser_out 0, ser_valid 0, frame_last 0, in_ready 1, busy 0. Internally state = IDLE, cnt 0, hold_full 0, shreg 0, hold 0.
- **Latency:** for a word accepted at edge N from IDLE:
  - bit WIDTH-1 is on ser_out during cycle N+1;
  - bit 0 is on ser_out during cycle N+WIDTH, with frame_last high;
  - the downstream deserializer shows the complete word after edge N+WIDTH.
- **Throughput:** one bit per clock. Back-to-back words, via hold or the bypass, produce ser_valid continuously high with no gap. frame_last pulses every WIDTH cycles.
- **Holding buffer:** at most one word is buffered. in_ready is low for the whole period hold_full is set, and rises the cycle after hold is drained into shreg.
- **Simultaneous events:** at the last-bit cycle with hold_full set, in_ready is already low, so no accept can collide.
- **Reset mid-frame:** the partial frame is abandoned. No frame_last is produced for it, the held word is discarded, and outputs return to reset values asynchronously.
- **in_valid without in_ready:** has no effect. The producer must hold in_valid and in_data until accepted.

## Structure
- **Shared package:** the state enum (IDLE, SHIFT) and the default WIDTH constant (4). The deserializer instance uses the same constant.
- **Sub-module:** one natural sub-module, word_hold_buf, containing the holding register, hold_full and the in_ready generation. The shifter, counter and state machine stay in the top level.
- **No combinational loops:** every output is a function of registered state only.

## Test plan
- **Reset:** assert rst mid-simulation. → All outputs are at their reset values immediately, without waiting for a clock edge.
- **Single word:** WIDTH=4, send 4'b1011 from IDLE at edge N. → ser_out is 1,0,1,1 in cycles N+1..N+4; frame_last is high only in cycle N+4; a downstream sipo shows out = 4'b1011 after edge N+4.
- **Streaming:** words 4'hA, 4'h5, 4'hF with in_valid held high. → 12 contiguous ser_valid cycles, serial stream 1010_0101_1111, frame_last in cycles 4, 8 and 12, and in_ready dropping while hold is full.
- **Bypass:** a word is offered only in the last-bit cycle, with hold empty. → It is accepted directly into shreg and its MSB appears the next cycle with no gap.
- **Reset mid-frame:** assert rst after 2 bits of 4'hC, with 4'h3 held in hold. → Output clears; after release, sending 4'h6 yields exactly 0,1,1,0 with no residue of 4'hC or 4'h3.
